// File: rtl/iter_mult_hs.sv
// ---------------------------------------------------------------------------
// iter_mult_hs
//   Radix-2 shift-add multiplier. Each cycle in RUN adds one partial product,
//   so a WIDTH x WIDTH multiply takes exactly WIDTH RUN cycles. Operands come
//   in and the product goes out through ready/valid handshakes.
//
//   Optional build macro: SIGNED_MODE_EN. When it is defined, the block has an
//   extra signed_mode input that selects a two's-complement multiply.
//
// Parameters:
//   WIDTH      operand width in bits (2..16); the product is 2*WIDTH bits
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   ena          global enable; when low, every register holds its value
//   in_valid     operands a/b are present
//   in_ready     block can accept operands (state IDLE)
//   a            multiplicand
//   b            multiplier
//   signed_mode  (SIGNED_MODE_EN only) treat a/b as two's complement
//   out_valid    product is valid (state DONE)
//   out_ready    consumer accepts the product
//   product      result register, holds its value until the next result
//   busy         high while in state RUN
// ---------------------------------------------------------------------------
module iter_mult_hs #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef SIGNED_MODE_EN
  input  logic                 signed_mode,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_product;

  logic             w_last;
  logic             w_subtract;
  logic [PW-1:0]    w_mcandExt;
  logic [PW-1:0]    w_partial;
  logic [PW-1:0]    w_accNext;

`ifdef SIGNED_MODE_EN
  logic             r_signed;
`endif

  // Handshake and status outputs are decoded purely from the registered state,
  // so there is never a combinational path from an input to these outputs.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_RUN);
  assign product   = r_product;

  assign w_last = (r_cnt == LAST_CNT);

  // The multiplicand is stored already widened to PW bits. In signed mode it is
  // sign-extended so the shifted partial products carry the sign correctly.
`ifdef SIGNED_MODE_EN
  assign w_mcandExt = signed_mode ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign w_subtract = r_signed && w_last;
`else
  assign w_mcandExt = {{WIDTH{1'b0}}, a};
  assign w_subtract = 1'b0;
`endif

  // One partial product per cycle. On the last cycle of a signed multiply the
  // multiplier bit under test is its sign bit, which carries negative weight.
  // That partial product is therefore subtracted instead of added.
  always_comb begin
    w_partial = r_mcand << r_cnt;
    w_accNext = r_acc;
    if (r_mplier[0]) begin
      if (w_subtract) begin
        w_accNext = r_acc - w_partial;
      end else begin
        w_accNext = r_acc + w_partial;
      end
    end
  end

  // Next-state decode. RUN always lasts exactly WIDTH cycles; it does not end
  // early when the remaining multiplier bits are zero.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_nextState = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // State register. When ena is low the FSM freezes in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (ena) begin
      r_state <= w_nextState;
    end
  end

  // Datapath registers. A reset during RUN or DONE drops the operation and
  // clears the product, so no stale result is presented afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
`ifdef SIGNED_MODE_EN
      r_signed  <= 1'b0;
`endif
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand  <= w_mcandExt;
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
`ifdef SIGNED_MODE_EN
            r_signed <= signed_mode;
`endif
          end
        end
        S_RUN: begin
          r_acc    <= w_accNext;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_product <= w_accNext;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_mult_hs.sv
// ---------------------------------------------------------------------------
// tb_iter_mult_hs
//   Self-checking bench for iter_mult_hs. It uses one WIDTH=4 instance and one
//   WIDTH=8 instance on a shared clock, reset and enable. Expected products are
//   pushed to a queue when operands are accepted. They are popped and compared
//   when the DUT presents its product.
// ---------------------------------------------------------------------------
module tb_iter_mult_hs;

  logic        clk;
  logic        rst_n;
  logic        ena;

  logic        inValid4;
  logic        inReady4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        signedMode4;
  logic        outValid4;
  logic        outReady4;
  logic [7:0]  product4;
  logic        busy4;

  logic        inValid8;
  logic        inReady8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        outValid8;
  logic        outReady8;
  logic [15:0] product8;
  logic        busy8;

  int          checks;
  int          errors;
  logic [7:0]  expQ4[$];
  logic [15:0] expQ8[$];

  iter_mult_hs #(.WIDTH(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .in_valid   (inValid4),
    .in_ready   (inReady4),
    .a          (a4),
    .b          (b4),
`ifdef SIGNED_MODE_EN
    .signed_mode(signedMode4),
`endif
    .out_valid  (outValid4),
    .out_ready  (outReady4),
    .product    (product4),
    .busy       (busy4)
  );

  iter_mult_hs #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .in_valid   (inValid8),
    .in_ready   (inReady8),
    .a          (a8),
    .b          (b8),
`ifdef SIGNED_MODE_EN
    .signed_mode(1'b0),
`endif
    .out_valid  (outValid8),
    .out_ready  (outReady8),
    .product    (product8),
    .busy       (busy8)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compute the reference product of the 4-bit instance.
  function automatic logic [7:0] model4(input logic [3:0] ta, input logic [3:0] tb, input logic sm);
    int sa;
    int sb;
    int p;
    sa = int'(ta);
    sb = int'(tb);
`ifdef SIGNED_MODE_EN
    if (sm) begin
      if (ta[3]) sa = sa - 16;
      if (tb[3]) sb = sb - 16;
    end
`else
    if (sm) begin
      sa = int'(ta);
    end
`endif
    p = sa * sb;
    return p[7:0];
  endfunction

  // Run one full operation on the 4-bit instance. During RUN the bench keeps
  // in_valid high with junk operands, and it can stall with ena=0. It also
  // holds out_ready low for holdCycles before it accepts the product.
  task automatic applyStimulus(input logic [3:0] ta, input logic [3:0] tb, input logic sm,
                               input int stallStart, input int stallLen,
                               input int holdCycles, input int expLat);
    int lat;
    int busyCnt;
    int unstable;
    logic [7:0] exp;
    logic [7:0] held;
    inValid4    = 1'b1;
    a4          = ta;
    b4          = tb;
    signedMode4 = sm;
    step();
    expQ4.push_back(model4(ta, tb, sm));
    checkOutput("inReadyAfterAccept", 32'(inReady4), 32'd0);
    lat     = 0;
    busyCnt = busy4 ? 1 : 0;
    while (!outValid4 && lat < 40) begin
      a4  = 4'($urandom);
      b4  = 4'($urandom);
      ena = !(lat >= stallStart && lat < stallStart + stallLen);
      step();
      lat++;
      if (busy4) busyCnt++;
    end
    ena      = 1'b1;
    inValid4 = 1'b0;
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("busyCycles", 32'(busyCnt), 32'(expLat));
    held     = product4;
    unstable = 0;
    for (int i = 0; i < holdCycles; i++) begin
      step();
      if (!outValid4 || product4 !== held) unstable++;
    end
    checkOutput("holdStable", 32'(unstable), 32'd0);
    exp = (expQ4.size() > 0) ? expQ4.pop_front() : 8'hxx;
    checkOutput("product4", 32'(product4), 32'(exp));
    outReady4 = 1'b1;
    step();
    outReady4 = 1'b0;
    checkOutput("inReadyAfterHandoff", 32'(inReady4), 32'd1);
    checkOutput("outValidAfterHandoff", 32'(outValid4), 32'd0);
    checkOutput("productKept", 32'(product4), 32'(exp));
  endtask

  // Run one operation on the 8-bit instance and check its latency and product.
  task automatic applyStimulus8(input logic [7:0] ta, input logic [7:0] tb);
    int lat;
    logic [15:0] exp;
    inValid8 = 1'b1;
    a8       = ta;
    b8       = tb;
    step();
    inValid8 = 1'b0;
    expQ8.push_back(16'(int'(ta) * int'(tb)));
    lat = 0;
    while (!outValid8 && lat < 40) begin
      step();
      lat++;
    end
    checkOutput("latency8", 32'(lat), 32'd8);
    exp = (expQ8.size() > 0) ? expQ8.pop_front() : 16'hxxxx;
    checkOutput("product8", 32'(product8), 32'(exp));
    outReady8 = 1'b1;
    step();
    outReady8 = 1'b0;
    checkOutput("inReady8AfterHandoff", 32'(inReady8), 32'd1);
  endtask

  // Main sequence.
  initial begin
    int sawValid;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    ena         = 1'b1;
    inValid4    = 1'b0;
    a4          = '0;
    b4          = '0;
    signedMode4 = 1'b0;
    outReady4   = 1'b0;
    inValid8    = 1'b0;
    a8          = '0;
    b8          = '0;
    outReady8   = 1'b0;
    step();
    step();
    checkOutput("resetInReady", 32'(inReady4), 32'd1);
    checkOutput("resetOutValid", 32'(outValid4), 32'd0);
    checkOutput("resetBusy", 32'(busy4), 32'd0);
    checkOutput("resetProduct", 32'(product4), 32'd0);
    checkOutput("resetInReady8", 32'(inReady8), 32'd1);
    rst_n = 1'b1;
    step();

    $display("[TB] basic 3*5 and 15*15 with a long hold");
    applyStimulus(4'd3, 4'd5, 1'b0, 100, 0, 0, 4);
    applyStimulus(4'd15, 4'd15, 1'b0, 100, 0, 10, 4);

    $display("[TB] WIDTH=8 extremes");
    applyStimulus8(8'd255, 8'd255);
    applyStimulus8(8'd0, 8'd200);

    $display("[TB] stall with ena low for three cycles");
    applyStimulus(4'd7, 4'd9, 1'b0, 1, 3, 2, 7);

    $display("[TB] random unsigned operands");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'($urandom), 4'($urandom), 1'b0, 100, 0, int'($urandom_range(0, 3)), 4);
    end

    $display("[TB] reset in the middle of RUN");
    inValid4 = 1'b1;
    a4       = 4'd6;
    b4       = 4'd6;
    step();
    inValid4 = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    checkOutput("abortInReady", 32'(inReady4), 32'd1);
    checkOutput("abortBusy", 32'(busy4), 32'd0);
    checkOutput("abortProduct", 32'(product4), 32'd0);
    step();
    rst_n    = 1'b1;
    sawValid = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (outValid4) sawValid = 1;
    end
    checkOutput("noValidAfterAbort", 32'(sawValid), 32'd0);
    applyStimulus(4'd2, 4'd3, 1'b0, 100, 0, 0, 4);

`ifdef SIGNED_MODE_EN
    $display("[TB] signed mode");
    applyStimulus(4'hD, 4'd5, 1'b1, 100, 0, 0, 4);
    applyStimulus(4'd8, 4'd8, 1'b1, 100, 0, 0, 4);
    applyStimulus(4'd8, 4'd8, 1'b0, 100, 0, 0, 4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'($urandom), 4'($urandom), 1'b1, 100, 0, 1, 4);
    end
`endif

    checkOutput("scoreboardEmpty", 32'(expQ4.size() + expQ8.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
